// File: rtl/branch_predict_resolve_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : branch_predict_resolve_unit                                |
// | Description : Resolves RV32I conditional branches in EX, keeps a bimodal |
// |               table of saturating counters for IF prediction, and issues |
// |               a registered flush/redirect one cycle after a mispredict.  |
// | Optional    : BRANCH_STATS_EN adds stat_branches_o / stat_mispredicts_o  |
// |               (32-bit saturating event counters).                       |
// | Ports       : clk_i, rst_i          clock, synchronous active-high reset |
// |               if_pc_i               fetch PC used for table lookup       |
// |               if_pred_taken_o       MSB of indexed counter (comb)        |
// |               ex_valid_i/branch_i   EX slot holds a conditional branch   |
// |               ex_funct3_i           branch condition select              |
// |               ex_operand_a_i/b_i    rs1 / rs2 values                     |
// |               ex_pc_i, ex_target_i  branch PC and taken target           |
// |               ex_pred_taken_i       prediction carried from IF           |
// |               ex_taken_o            resolved outcome (comb)              |
// |               ex_illegal_o          funct3 010/011 while resolving       |
// |               flush_o               registered mispredict flush          |
// |               redirect_pc_o         registered correct next PC           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module branch_predict_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            if_pred_taken_o,
  input  logic            ex_valid_i,
  input  logic            ex_branch_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [XLEN-1:0] ex_operand_a_i,
  input  logic [XLEN-1:0] ex_operand_b_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            ex_pred_taken_i,
  output logic            ex_taken_o,
  output logic            ex_illegal_o,
  output logic            flush_o,
  output logic [XLEN-1:0] redirect_pc_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches_o,
  output logic [31:0]     stat_mispredicts_o
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] c_ctr_max  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] c_ctr_zero = {CTR_BITS{1'b0}};
  // Weakly not-taken: 0111..1
  localparam logic [CTR_BITS-1:0] c_ctr_init = {1'b0, {(CTR_BITS-1){1'b1}}};

  logic [CTR_BITS-1:0] bht_q [BHT_ENTRIES];
  logic                flush_q;
  logic [XLEN-1:0]     redirect_q;

  logic [IDX_W-1:0]    w_if_idx;
  logic [IDX_W-1:0]    w_ex_idx;
  logic                w_squash;
  logic                w_resolve;
  logic                w_illegal_f3;
  logic                w_cond;
  logic                w_update;
  logic                w_mispredict;
  logic [CTR_BITS-1:0] w_ex_ctr;
  logic [CTR_BITS-1:0] ctr_d;
  logic [XLEN-1:0]     redirect_d;

  // PC bits outside the index field do not address the table.
  logic unused_if_pc_bits;
  assign unused_if_pc_bits = ^{if_pc_i[XLEN-1:IDX_W+2], if_pc_i[1:0]};

  assign w_if_idx = if_pc_i[IDX_W+1:2];
  assign w_ex_idx = ex_pc_i[IDX_W+1:2];

  // Lookup reads the registered table only, so a same-cycle update to the
  // same entry is not visible until the following cycle.
  assign if_pred_taken_o = bht_q[w_if_idx][CTR_BITS-1];

  // The instruction in EX during the flush cycle is wrong-path.
  assign w_squash     = flush_q;
  assign w_resolve    = ex_valid_i & ex_branch_i & ~w_squash;
  assign w_illegal_f3 = (ex_funct3_i[2:1] == 2'b01);

  always_comb begin
    w_cond = 1'b0;
    case (ex_funct3_i)
      3'b000:  w_cond = (ex_operand_a_i == ex_operand_b_i);
      3'b001:  w_cond = (ex_operand_a_i != ex_operand_b_i);
      3'b100:  w_cond = ($signed(ex_operand_a_i) <  $signed(ex_operand_b_i));
      3'b101:  w_cond = ($signed(ex_operand_a_i) >= $signed(ex_operand_b_i));
      3'b110:  w_cond = (ex_operand_a_i <  ex_operand_b_i);
      3'b111:  w_cond = (ex_operand_a_i >= ex_operand_b_i);
      default: w_cond = 1'b0;
    endcase
  end

  assign ex_taken_o   = w_resolve & w_cond;
  assign ex_illegal_o = w_resolve & w_illegal_f3;
  assign w_update     = w_resolve & ~w_illegal_f3;
  assign w_mispredict = w_update & (ex_taken_o != ex_pred_taken_i);

  // Saturating counter step for the resolving entry.
  always_comb begin
    w_ex_ctr = bht_q[w_ex_idx];
    ctr_d    = w_ex_ctr;
    if (ex_taken_o) begin
      if (w_ex_ctr != c_ctr_max) begin
        ctr_d = w_ex_ctr + CTR_BITS'(1);
      end
    end else if (w_ex_ctr != c_ctr_zero) begin
      ctr_d = w_ex_ctr - CTR_BITS'(1);
    end
  end

  assign redirect_d = ex_taken_o ? ex_target_i : (ex_pc_i + XLEN'(4));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= c_ctr_init;
      end
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      if (w_update) begin
        bht_q[w_ex_idx] <= ctr_d;
      end
      flush_q <= w_mispredict;
      if (w_mispredict) begin
        redirect_q <= redirect_d;
      end
    end
  end

  assign flush_o       = flush_q;
  assign redirect_pc_o = redirect_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_br_q <= 32'd0;
      stat_mp_q <= 32'd0;
    end else begin
      if (w_update && (stat_br_q != 32'hFFFF_FFFF)) begin
        stat_br_q <= stat_br_q + 32'd1;
      end
      if (w_mispredict && (stat_mp_q != 32'hFFFF_FFFF)) begin
        stat_mp_q <= stat_mp_q + 32'd1;
      end
    end
  end

  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mp_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_resolve_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_branch_predict_resolve_unit                             |
// | Description : Self-checking bench: vector table, directed corner        |
// |               sequences and random traffic against a behavioural model. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_branch_predict_resolve_unit;

  localparam int N_ENT   = 64;
  localparam int CTR_MAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_branch;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_a, ex_b, ex_pc, ex_target;
  logic        ex_pred;
  logic        ex_taken, ex_illegal, flush;
  logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br, stat_mp;
`endif

  always #5 clk = ~clk;

  branch_predict_resolve_unit #(.XLEN(32), .BHT_ENTRIES(N_ENT), .CTR_BITS(2)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .if_pc_i         (if_pc),
    .if_pred_taken_o (if_pred_taken),
    .ex_valid_i      (ex_valid),
    .ex_branch_i     (ex_branch),
    .ex_funct3_i     (ex_funct3),
    .ex_operand_a_i  (ex_a),
    .ex_operand_b_i  (ex_b),
    .ex_pc_i         (ex_pc),
    .ex_target_i     (ex_target),
    .ex_pred_taken_i (ex_pred),
    .ex_taken_o      (ex_taken),
    .ex_illegal_o    (ex_illegal),
    .flush_o         (flush),
    .redirect_pc_o   (redirect_pc)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches_o    (stat_br),
    .stat_mispredicts_o (stat_mp)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int          m_ctr [N_ENT];
  logic        m_flush;
  logic [31:0] m_redir;
  int unsigned m_sb, m_sm;

  // Last sampled combinational outputs
  logic s_pred, s_taken, s_ill;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_ENT; i++) m_ctr[i] = 1;
    m_flush = 1'b0;
    m_redir = 32'h0;
    m_sb    = 0;
    m_sm    = 0;
  endtask

  // One clock: drive, check combinational outputs, clock, advance model,
  // check registered outputs.
  task automatic step(input logic rs, input logic v, input logic br, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic pred, input logic [31:0] ipc);
    logic res, ill, tk, mp, ep;
    int   ii, ei;
    rst = rs; ex_valid = v; ex_branch = br; ex_funct3 = f3; ex_a = a; ex_b = b;
    ex_pc = pc; ex_target = tgt; ex_pred = pred; if_pc = ipc;
    #1;
    ii  = int'((ipc >> 2) % N_ENT);
    ei  = int'((pc >> 2) % N_ENT);
    res = v && br && !m_flush;
    ill = res && (f3 == 3'd2 || f3 == 3'd3);
    tk  = res && !ill && m_cond(f3, a, b);
    mp  = res && !ill && (tk != pred);
    ep  = (m_ctr[ii] >= 2);
    s_pred = if_pred_taken; s_taken = ex_taken; s_ill = ex_illegal;
    chk("if_pred_taken", {31'b0, if_pred_taken}, {31'b0, ep});
    chk("ex_taken", {31'b0, ex_taken}, {31'b0, tk});
    chk("ex_illegal", {31'b0, ex_illegal}, {31'b0, ill});
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
      if (res && !ill) begin
        if (tk) m_ctr[ei] = (m_ctr[ei] == CTR_MAX) ? CTR_MAX : m_ctr[ei] + 1;
        else    m_ctr[ei] = (m_ctr[ei] == 0) ? 0 : m_ctr[ei] - 1;
        if (m_sb != 32'hFFFF_FFFF) m_sb++;
      end
      if (mp) begin
        m_redir = tk ? tgt : pc + 32'd4;
        if (m_sm != 32'hFFFF_FFFF) m_sm++;
      end
      m_flush = mp;
    end
    #1;
    chk("flush", {31'b0, flush}, {31'b0, m_flush});
    chk("redirect_pc", redirect_pc, m_redir);
`ifdef BRANCH_STATS_EN
    chk("stat_branches", stat_br, m_sb);
    chk("stat_mispredicts", stat_mp, m_sm);
`endif
  endtask

  task automatic idle(input logic [31:0] ipc);
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, ipc);
  endtask

  typedef struct {
    string       nm;
    logic [2:0]  f3;
    logic [31:0] a, b, pc, tgt;
    logic        pred, exp_taken, exp_ill, exp_flush;
    logic [31:0] exp_redir;
  } vec_t;

  vec_t vt [8];

  initial begin
    vt[0] = '{"BNE",    3'd1, 32'd5,         32'd10,        32'h204, 32'h1000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[1] = '{"BLT",    3'd4, 32'hFFFF_FFF6, 32'hFFFF_FFFB, 32'h208, 32'h1000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[2] = '{"BGE",    3'd5, 32'd5,         32'd5,         32'h20C, 32'h1000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[3] = '{"BLTU",   3'd6, 32'd10,        32'hFFFF_FFFF, 32'h210, 32'h1000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[4] = '{"BGEU",   3'd7, 32'hFFFF_FFFF, 32'd10,        32'h214, 32'h1000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[5] = '{"BLTwrap",3'd4, 32'd10,        32'd5,         32'hFFFF_FFFC, 32'h500, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vt[6] = '{"ILL010", 3'd2, 32'd0,         32'd0,         32'h218, 32'h1000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[7] = '{"BEQnt",  3'd0, 32'd7,         32'd8,         32'h21C, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

    // Bring the DUT out of its unknown power-up state before checking.
    rst = 1'b1; ex_valid = 1'b0; ex_branch = 1'b0; ex_funct3 = 3'd0; ex_a = '0; ex_b = '0;
    ex_pc = '0; ex_target = '0; ex_pred = 1'b0; if_pc = '0;
    @(posedge clk); #1;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 32'h100);
    chk("reset flush", {31'b0, flush}, 32'd0);
    chk("reset redirect", redirect_pc, 32'd0);

    // First lookup, then taken BEQ against a not-taken prediction.
    idle(32'h100);
    chk("pred 0x100 initial", {31'b0, s_pred}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 3'd0, 32'd5, 32'd5, 32'h100, 32'h140, 1'b0, 32'h100);
    chk("BEQ taken", {31'b0, s_taken}, 32'd1);
    chk("BEQ flush", {31'b0, flush}, 32'd1);
    chk("BEQ redirect", redirect_pc, 32'h140);
    idle(32'h100);
    chk("pred 0x100 after", {31'b0, s_pred}, 32'd1);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1, vt[i].f3, vt[i].a, vt[i].b, vt[i].pc, vt[i].tgt, vt[i].pred, vt[i].pc);
      chk({vt[i].nm, " taken"}, {31'b0, s_taken}, {31'b0, vt[i].exp_taken});
      chk({vt[i].nm, " illegal"}, {31'b0, s_ill}, {31'b0, vt[i].exp_ill});
      chk({vt[i].nm, " flush"}, {31'b0, flush}, {31'b0, vt[i].exp_flush});
      if (vt[i].exp_flush) chk({vt[i].nm, " redirect"}, redirect_pc, vt[i].exp_redir);
      idle(32'h0);
    end

    // Illegal left entry 0x218 at 01: one taken update must make it predict taken.
    step(1'b0, 1'b1, 1'b1, 3'd0, 32'd1, 32'd1, 32'h218, 32'h800, 1'b0, 32'h218);
    idle(32'h218);
    idle(32'h218);
    chk("pred 0x218 after illegal+taken", {31'b0, s_pred}, 32'd1);

    // Branch in the flush cycle is squashed: no flush, no table update.
    step(1'b0, 1'b1, 1'b1, 3'd0, 32'd3, 32'd3, 32'h220, 32'h900, 1'b0, 32'h0);
    chk("b2b first flush", {31'b0, flush}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 3'd1, 32'd1, 32'd2, 32'h224, 32'h900, 1'b0, 32'h0);
    chk("squashed taken", {31'b0, s_taken}, 32'd0);
    chk("no second flush", {31'b0, flush}, 32'd0);
    idle(32'h224);
    chk("squashed counter unchanged", {31'b0, s_pred}, 32'd0);

    // Saturation at 11 on index of 0x230.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b1, 3'd0, 32'd4, 32'd4, 32'h230, 32'hA00, 1'b1, 32'h230);
      idle(32'h230);
    end
    idle(32'h230);
    chk("pred 0x230 saturated", {31'b0, s_pred}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 3'd1, 32'd4, 32'd4, 32'h230, 32'hA00, 1'b1, 32'h230);
    chk("not-taken redirect pc+4", redirect_pc, 32'h234);
    idle(32'h230);
    idle(32'h230);
    chk("pred 0x230 after one dec", {31'b0, s_pred}, 32'd1);

    // Reset overrides a mispredicting resolve in the same cycle.
    step(1'b1, 1'b1, 1'b1, 3'd0, 32'd2, 32'd2, 32'h230, 32'hB00, 1'b0, 32'h230);
    chk("rst flush", {31'b0, flush}, 32'd0);
    chk("rst redirect", redirect_pc, 32'd0);
    idle(32'h230);
    chk("pred 0x230 after rst", {31'b0, s_pred}, 32'd0);

`ifdef BRANCH_STATS_EN
    step(1'b1, 1'b0, 1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 3'd0, 32'd1, 32'd1, 32'h300, 32'h0, 1'b1, 0);
    step(1'b0, 1'b1, 1'b1, 3'd1, 32'd1, 32'd2, 32'h304, 32'h0, 1'b1, 0);
    step(1'b0, 1'b1, 1'b1, 3'd0, 32'd1, 32'd2, 32'h308, 32'h0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 3'd6, 32'd1, 32'd2, 32'h30C, 32'h0, 1'b0, 0);
    idle(0);
    chk("stat_branches=4", stat_br, 32'd4);
    chk("stat_mispredicts=1", stat_mp, 32'd1);
    step(1'b1, 1'b0, 1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 0);
    chk("stat_branches rst", stat_br, 32'd0);
    chk("stat_mispredicts rst", stat_mp, 32'd0);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      logic [31:0] ra, rb, rpc, rtgt, ripc;
      ra   = $urandom;
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra + 32'($urandom_range(0, 3)) - 32'd1;
        default: rb = $urandom;
      endcase
      rpc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'h1000 + 32'($urandom_range(0, 15) << 2);
      rtgt = $urandom & 32'hFFFF_FFFC;
      ripc = 32'h1000 + 32'($urandom_range(0, 15) << 2);
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           3'($urandom_range(0, 7)), ra, rb, rpc, rtgt, 1'($urandom_range(0, 1)), ripc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predict_resolve_unit.md
Name: branch_predict_resolve_unit

Overview:
- Parametrised successor to the combinational RV32I branch comparator.
- Resolves all six RV32I branch conditions in EX.
- Keeps a bimodal branch history table (BHT) of saturating counters; IF reads it for prediction, EX updates it on resolution.
- Detects mispredictions and issues a registered flush/redirect to IF/ID one cycle after resolution.

Parameters:
- XLEN, 32, operand/PC width.
- BHT_ENTRIES, 64, number of counters; power of two, at least 2.
- CTR_BITS, 2, saturating counter width; at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- if_pc  in  XLEN  fetch PC for lookup.
- if_pred_taken  out  1  prediction for if_pc: MSB of the indexed counter; combinational.
- ex_valid  in  1  EX slot holds a valid instruction.
- ex_branch  in  1  EX instruction is a conditional branch.
- ex_funct3  in  3  branch funct3.
- ex_operand_a  in  XLEN  rs1 value.
- ex_operand_b  in  XLEN  rs2 value.
- ex_pc  in  XLEN  branch PC.
- ex_target  in  XLEN  branch target (pc+imm).
- ex_pred_taken  in  1  prediction carried down the pipe from IF.
- ex_taken  out  1  resolved outcome; combinational.
- ex_illegal  out  1  funct3 is 010 or 011 while resolving; combinational.
- flush  out  1  registered mispredict flush.
- redirect_pc  out  XLEN  registered correct next PC, valid when flush=1.

Behaviour:
- Index: pc[$clog2(BHT_ENTRIES)+1:2], for both the IF read and the EX write.
- resolve = ex_valid & ex_branch & ~squash.
- Conditions:
  - 000 BEQ: equal.
  - 001 BNE: not equal.
  - 100 BLT: signed less-than.
  - 101 BGE: signed greater-or-equal.
  - 110 BLTU: unsigned less-than.
  - 111 BGEU: unsigned greater-or-equal.
  - Full XLEN compare.
- ex_taken = resolve & condition. ex_taken=0 for 010/011.
- ex_illegal = resolve & (funct3 is 010 or 011).
- Counter update on the clock edge when resolve & ~ex_illegal:
  - taken: increment, saturating at all-ones.
  - not taken: decrement, saturating at 0.
  - Illegal funct3: no update.
- mispredict = resolve & ~ex_illegal & (ex_taken != ex_pred_taken).
- Next-cycle registers:
  - flush <= mispredict.
  - redirect_pc <= ex_taken ? ex_target : ex_pc + 4, with modulo-2^XLEN wrap.
  - redirect_pc holds its value when flush=0.
- squash is an internal 1-bit register equal to the registered flush. While squash=1, the EX instruction is wrong-path:
  - no table update.
  - ex_taken=0, ex_illegal=0.
  - no new flush, so back-to-back flushes are impossible.
- Same-index read/write in one cycle: if_pred_taken returns the pre-update value. No bypass.
- Reset (rst=1 at a clock edge), all in that single cycle:
  - every counter <= 2^(CTR_BITS-1)-1 (weakly not-taken; 01 for 2 bits).
  - flush=0, redirect_pc=0, squash=0.
- rst asserted mid-operation overrides any pending update or flush in that cycle.
- While rst=1, if_pred_taken reflects the current table contents.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, add two outputs, each 32 bits wide, saturating at 32'hFFFFFFFF and reset to 0:
  - stat_branches: increments on each resolve & ~ex_illegal.
  - stat_mispredicts: increments on each mispredict.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then if_pc=0x100 → if_pred_taken=0. Resolve BEQ at ex_pc=0x100 with a=b=5, pred=0 → ex_taken=1, next cycle flush=1 and redirect_pc=ex_target=0x140. Next lookup of 0x100 → if_pred_taken=1 (counter now 10).
- Resolve the BNE/BLT/BGE/BLTU/BGEU vectors with their stated pred:
  - BNE 5 vs 10.
  - BLT −10 vs −5.
  - BGE 5 vs 5.
  - BLTU 10 vs 0xFFFFFFFF.
  - BGEU 0xFFFFFFFF vs 10.
  - Required response: ex_taken=1 and flush=0 for each.
- Resolve BLT 10 vs 5 with pred=1 at ex_pc=0xFFFFFFFC → ex_taken=0, next cycle flush=1 and redirect_pc=0x00000000 (wrap).
- Mispredict, then present ex_valid=1, ex_branch=1 in the flush cycle with a mispredicting outcome → no second flush, and that instruction's counter is unchanged.
- funct3=010 with ex_valid=1, ex_branch=1 → ex_illegal=1, ex_taken=0, no counter change, flush stays 0. Taken branch ×3 on one index → counter saturates at 11. Then rst for one cycle → counter 01, flush=0.
- With BRANCH_STATS_EN defined: 4 branches, 1 of them mispredicted → stat_branches=4, stat_mispredicts=1. After rst → both 0.
